// File: rtl/serial_wide_adder_ctrl.sv
// serial_wide_adder_ctrl
// Builds an 8*N_BYTES-bit adder from one external 8-bit adder by feeding it
// one byte slice per cycle, LSB first, and rippling the carry through a flop.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE, so
// accepting a new operand pair and completing a result never share a cycle;
// inputs on the side that is not ready are ignored.
module serial_wide_adder_ctrl #(
    parameter int N_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*N_BYTES-1:0]   op_a,
    input  logic [8*N_BYTES-1:0]   op_b,
    input  logic                   op_cin,
    output logic [7:0]             add_a,
    output logic [7:0]             add_b,
    output logic                   add_cin,
    input  logic [7:0]             add_sum,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*N_BYTES-1:0]   result,
    output logic                   result_cout,
    output logic                   result_ovf,
    output logic [1:0]             dbg_state
);

    localparam int W  = 8 * N_BYTES;
    localparam int IW = $clog2(N_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;

    assign dbg_state = state;

    // Sequencer: accept operands, step one byte per cycle, hold result until taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            result      <= '0;
            result_cout <= 1'b0;
            result_ovf  <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg       <= op_a;
                        b_reg       <= op_b;
                        carry       <= op_cin;
                        idx         <= '0;
                        // clear so bytes of the previous result never leak into this one
                        result      <= '0;
                        result_cout <= 1'b0;
                        result_ovf  <= 1'b0;
                        in_ready    <= 1'b0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    result[8*idx +: 8] <= add_sum;
                    carry              <= add_cout;
                    if (idx == LAST_IDX) begin
                        // last slice: add_sum[7] is the MSB of the final sum
                        result_cout <= add_cout;
                        result_ovf  <= (a_reg[W-1] == b_reg[W-1]) &&
                                       (add_sum[7] != a_reg[W-1]);
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Adder drive: current byte slice while running, quiet zeros otherwise
    always_comb begin
        add_a   = 8'h00;
        add_b   = 8'h00;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[8*idx +: 8];
            add_b   = b_reg[8*idx +: 8];
            add_cin = carry;
        end
    end

endmodule

// File: tb/tb_serial_wide_adder_ctrl.sv
// Bench for serial_wide_adder_ctrl with N_BYTES=4 and a combinational
// 8-bit adder model closing the loop. Expected results come from plain
// 33-bit arithmetic on the whole operands.
module tb_serial_wide_adder_ctrl;

    localparam int N = 4;
    localparam int W = 8 * N;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          op_cin = 1'b0;
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic          add_cin;
    logic [7:0]    add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          result_cout;
    logic          result_ovf;
    logic [1:0]    dbg_state;

    int vectors = 0;
    int miscompares = 0;

    // scoreboard entries: {ovf, cout, sum}
    logic [W+1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    // the external 8-bit adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

    serial_wide_adder_ctrl #(.N_BYTES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_cin      (op_cin),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_cin     (add_cin),
        .add_sum     (add_sum),
        .add_cout    (add_cout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_cout (result_cout),
        .result_ovf  (result_ovf),
        .dbg_state   (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // reference model: whole-word arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        logic [W:0] full;
        logic       ovf;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full[W], full[W-1:0]};
    endfunction

    // drive one operation end to end; hold = DONE cycles with out_ready low
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int hold);
        logic [W+1:0] e;
        int n;
        int i;
        exp_q.push_back(model(a, b, cin));
        @(negedge clk);
        op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        // accepted on the edge just passed; operands may now change freely
        in_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; op_cin = 1'($urandom_range(0, 1));
        check("in_ready_run", 64'(in_ready), 64'd0);
        i = 0;
        while (!out_valid && i < 20) begin
            if (i < N) begin
                check("add_a_byte", 64'(add_a), 64'(a[8*i +: 8]));
                check("add_b_byte", 64'(add_b), 64'(b[8*i +: 8]));
            end
            if (i == 0) check("add_cin_first", 64'(add_cin), 64'(cin));
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            i++;
        end
        out_ready = 1'b0;
        check("latency", 64'(i), 64'(N));
        e = exp_q.pop_front();
        check("result", 64'(result), 64'(e[W-1:0]));
        check("result_cout", 64'(result_cout), 64'(e[W]));
        check("result_ovf", 64'(result_ovf), 64'(e[W+1]));
        check("add_a_done", 64'(add_a), 64'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            op_a = $urandom; op_b = $urandom;
            @(negedge clk);
            check("hold_result", 64'(result), 64'(e[W-1:0]));
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_back", 64'(in_ready), 64'd1);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_cout", 64'(result_cout), 64'd0);
        check("rst_ovf", 64'(result_ovf), 64'd0);
        check("rst_add_a", 64'(add_a), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // directed corner cases
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        run_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 10);

        // reset in the middle of a run, at idx 2
        @(negedge clk);
        op_a = 32'h0000_00FF; op_b = 32'h0000_0001; op_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_add_a_idx2", 64'(add_a), 64'h00);
        check("mid_partial", 64'(result), 64'h100);
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_add_a", 64'(add_a), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);

        // randomized traffic, with some operands biased toward carry chains
        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFFF;
            if ($urandom_range(0, 3) == 0) rb = {1'b0, 31'($urandom)};
            run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // overall time guard
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
